// File: rtl/ctx_arb_pkg.sv
// Shared types and defaults for the context-engine memory arbiter.
// Each in-flight transaction is remembered as {issuing port id, write flag}.
package ctx_arb_pkg;

    localparam int MAX_PORTS            = 8;
    localparam int ID_W                 = $clog2(MAX_PORTS);
    localparam int DEFAULT_STARVE_LIMIT = 8;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            we;
    } txn_entry_t;

endpackage

// File: rtl/ctx_arb_txn_fifo.sv
// In-flight transaction FIFO: remembers which port issued each outstanding
// request so its response can be routed back in order.
module ctx_arb_txn_fifo
    import ctx_arb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push,
    input  logic          pop,
    input  txn_entry_t    din,
    output txn_entry_t    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    txn_entry_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ctx_mem_arbiter.sv
// N-port OBI data-bus arbiter: CPU (port 0) has fixed priority, context engines
// share the rest round-robin with starvation override. CTX_ARB_RESP_REG_EN registers the response path.
module ctx_mem_arbiter
    import ctx_arb_pkg::*;
#(
    parameter  int                 N_PORTS         = 2,
    parameter  int                 AW              = 32,
    parameter  int                 DW              = 32,
    parameter  int                 MAX_OUTSTANDING = 4,
    parameter  int                 STARVE_LIMIT    = DEFAULT_STARVE_LIMIT,
    parameter  logic [N_PORTS-1:0] DROP_WR_RESP    = '0,
    localparam int                 BW              = DW / 8,
    localparam int                 OW              = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_PORTS-1:0]    req_i,
    output logic [N_PORTS-1:0]    gnt_o,
    input  logic [N_PORTS-1:0]    we_i,
    input  logic [N_PORTS*BW-1:0] be_i,
    input  logic [N_PORTS*AW-1:0] addr_i,
    input  logic [N_PORTS*DW-1:0] wdata_i,
    output logic [N_PORTS-1:0]    rvalid_o,
    output logic [DW-1:0]         rdata_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic                  data_we_o,
    output logic [BW-1:0]         data_be_o,
    output logic [AW-1:0]         data_addr_o,
    output logic [DW-1:0]         data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [DW-1:0]         data_rdata_i,
    output logic [OW-1:0]         outstanding_o,
    output logic                  err_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [ID_W-1:0]    sel;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    lock_sel;
    logic               locked;
    logic [SW-1:0]      starve_cnt [1:N_PORTS-1];
    logic               req_sel;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    txn_entry_t         head;
    logic [N_PORTS-1:0] rvalid_c;

    // A stalled address phase keeps its port until granted; otherwise starving
    // engines first, then the CPU, then round-robin among the engines.
    always_comb begin : select_port
        logic found;
        int   idx;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        if (locked) begin
            sel   = lock_sel;
            found = 1'b1;
        end
        for (int p = 1; p < N_PORTS; p++) begin
            if (!found && req_i[p] && starve_cnt[p] >= SW'(STARVE_LIMIT)) begin
                sel   = ID_W'(p);
                found = 1'b1;
            end
        end
        if (!found && req_i[0]) found = 1'b1;
        for (int k = 0; k < N_PORTS - 1; k++) begin
            idx = (int'(rr_ptr) - 1 + k) % (N_PORTS - 1) + 1;
            if (!found && req_i[idx]) begin
                sel   = ID_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin : issue_mux
        req_sel      = req_i[0];
        data_we_o    = we_i[0];
        data_be_o    = be_i[BW-1:0];
        data_addr_o  = addr_i[AW-1:0];
        data_wdata_o = wdata_i[DW-1:0];
        for (int p = 1; p < N_PORTS; p++) begin
            if (sel == ID_W'(p)) begin
                req_sel      = req_i[p];
                data_we_o    = we_i[p];
                data_be_o    = be_i[p*BW +: BW];
                data_addr_o  = addr_i[p*AW +: AW];
                data_wdata_o = wdata_i[p*DW +: DW];
            end
        end
    end

    // Full blocks issue even when a pop lands in the same cycle, keeping rvalid off the request path.
    assign data_req_o = req_sel & ~fifo_full;
    assign push       = data_req_o & data_gnt_i;
    assign pop        = data_rvalid_i & ~fifo_empty;

    always_comb begin : route
        gnt_o    = '0;
        rvalid_c = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            gnt_o[p]    = push && (sel == ID_W'(p));
            rvalid_c[p] = pop && (head.id == ID_W'(p)) && !(DROP_WR_RESP[p] && head.we);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr   <= ID_W'(1);
            locked   <= 1'b0;
            lock_sel <= '0;
            err_o    <= 1'b0;
            for (int p = 1; p < N_PORTS; p++) starve_cnt[p] <= '0;
        end else begin
            locked   <= data_req_o & ~data_gnt_i;
            lock_sel <= sel;
            if (push && sel != '0)
                rr_ptr <= (sel == ID_W'(N_PORTS - 1)) ? ID_W'(1) : sel + 1'b1;
            if (data_rvalid_i && fifo_empty) err_o <= 1'b1;
            for (int p = 1; p < N_PORTS; p++) begin
                if (gnt_o[p] || !req_i[p])
                    starve_cnt[p] <= '0;
                else if (starve_cnt[p] < SW'(STARVE_LIMIT))
                    starve_cnt[p] <= starve_cnt[p] + 1'b1;
            end
        end
    end

    ctx_arb_txn_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_txn_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .pop    (pop),
        .din    ('{id: sel, we: data_we_o}),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (outstanding_o)
    );

`ifdef CTX_ARB_RESP_REG_EN
    logic [N_PORTS-1:0] rvalid_q;
    logic [DW-1:0]      rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_c;
            if (pop) rdata_q <= data_rdata_i;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
`else
    assign rvalid_o = rvalid_c;
    assign rdata_o  = data_rdata_i;
`endif

endmodule

// File: tb/tb_ctx_mem_arbiter.sv
// Self-checking bench for ctx_mem_arbiter (N=3): directed scenarios plus a
// randomized OBI traffic run, all compared against a queue-based reference model.
module tb_ctx_mem_arbiter;

    localparam int            N    = 3;
    localparam int            AW   = 32;
    localparam int            DW   = 32;
    localparam int            BW   = DW / 8;
    localparam int            MO   = 4;
    localparam int            LIM  = 8;
    localparam logic [N-1:0]  DROP = 3'b010;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [N-1:0]    req_i, gnt_o, we_i, rvalid_o;
    logic [N*BW-1:0] be_i;
    logic [N*AW-1:0] addr_i;
    logic [N*DW-1:0] wdata_i;
    logic [DW-1:0]   rdata_o, data_rdata_i, data_wdata_o;
    logic            data_req_o, data_gnt_i, data_we_o, data_rvalid_i, err_o;
    logic [BW-1:0]   data_be_o;
    logic [AW-1:0]   data_addr_o;
    logic [2:0]      outstanding_o;

    always #5 clk_i = ~clk_i;

    ctx_mem_arbiter #(
        .N_PORTS         (N),
        .AW              (AW),
        .DW              (DW),
        .MAX_OUTSTANDING (MO),
        .STARVE_LIMIT    (LIM),
        .DROP_WR_RESP    (DROP)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .gnt_o         (gnt_o),
        .we_i          (we_i),
        .be_i          (be_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .rvalid_o      (rvalid_o),
        .rdata_o       (rdata_o),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_addr_o   (data_addr_o),
        .data_wdata_o  (data_wdata_o),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

    int vectors = 0;
    int miscompares = 0;

    // Per-port requester state and downstream memory stimulus
    logic          pr [N];
    logic          pw [N];
    logic [BW-1:0] pbe [N];
    logic [AW-1:0] pa [N];
    logic [DW-1:0] pd [N];
    logic          dgnt, drv;
    logic [DW-1:0] drdata;

    // Reference model state
    typedef struct {
        int id;
        bit we;
    } txn_t;
    txn_t          mq[$];
    int            mstv [N];
    int            mrr;
    int            mlock;
    bit            merr;
    int            esel;
    bit            ereq, egnt, epop;
    logic [N-1:0]  erv, erv_q;
    logic [DW-1:0] erdata_q;

    // Snapshots of DUT outputs taken at the compare point
    logic [N-1:0]  s_gnt, s_rv;
    logic          s_req, s_err;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_rdata;
    logic [2:0]    s_out;

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic packInputs();
        for (int p = 0; p < N; p++) begin
            req_i[p]              = pr[p];
            we_i[p]               = pw[p];
            be_i[p*BW +: BW]      = pbe[p];
            addr_i[p*AW +: AW]    = pa[p];
            wdata_i[p*DW +: DW]   = pd[p];
        end
        data_gnt_i    = dgnt;
        data_rvalid_i = drv;
        data_rdata_i  = drdata;
    endtask

    task automatic setReq(input int p, input logic w, input logic [AW-1:0] a);
        pr[p]  = 1'b1;
        pw[p]  = w;
        pa[p]  = a;
        pbe[p] = 4'($urandom);
        pd[p]  = $urandom;
    endtask

    task automatic idle();
        for (int p = 0; p < N; p++) pr[p] = 1'b0;
        dgnt = 1'b0;
        drv  = 1'b0;
    endtask

    // Evaluates the arbitration rules on the model state and checks every output.
    task automatic checkOutput();
        logic [N-1:0]  exp_gnt, rv_exp;
        logic [DW-1:0] rd_exp;
        int            p;
        esel = -1;
        if (mlock >= 0) esel = mlock;
        else begin
            for (int i = 1; i < N; i++) if (esel < 0 && pr[i] && mstv[i] >= LIM) esel = i;
            if (esel < 0 && pr[0]) esel = 0;
            for (int k = 0; k < N - 1; k++) begin
                p = (mrr - 1 + k) % (N - 1) + 1;
                if (esel < 0 && pr[p]) esel = p;
            end
            if (esel < 0) esel = 0;
        end
        ereq    = pr[esel] && (mq.size() < MO);
        egnt    = ereq && dgnt;
        exp_gnt = egnt ? (N'(1) << esel) : '0;
        epop    = drv && (mq.size() > 0);
        erv     = '0;
        if (epop && !(DROP[mq[0].id] && mq[0].we)) erv[mq[0].id] = 1'b1;
`ifdef CTX_ARB_RESP_REG_EN
        rv_exp = erv_q;
        rd_exp = erdata_q;
`else
        rv_exp = erv;
        rd_exp = drdata;
`endif
        s_gnt = gnt_o; s_rv = rvalid_o; s_req = data_req_o; s_err = err_o;
        s_addr = data_addr_o; s_rdata = rdata_o; s_out = outstanding_o;
        compare("gnt_o", 64'(gnt_o), 64'(exp_gnt));
        compare("data_req_o", 64'(data_req_o), 64'(ereq));
        compare("data_we_o", 64'(data_we_o), 64'(pw[esel]));
        compare("data_be_o", 64'(data_be_o), 64'(pbe[esel]));
        compare("data_addr_o", 64'(data_addr_o), 64'(pa[esel]));
        compare("data_wdata_o", 64'(data_wdata_o), 64'(pd[esel]));
        compare("rvalid_o", 64'(rvalid_o), 64'(rv_exp));
        if (rv_exp != '0) compare("rdata_o", 64'(rdata_o), 64'(rd_exp));
        compare("outstanding_o", 64'(outstanding_o), 64'(mq.size()));
        compare("err_o", 64'(err_o), 64'(merr));
    endtask

    task automatic modelUpdate();
        txn_t t;
        erv_q = erv;
        if (epop) erdata_q = drdata;
        if (epop) t = mq.pop_front();
        else if (drv) merr = 1'b1;
        if (egnt) begin
            mq.push_back('{id: esel, we: pw[esel]});
            if (esel >= 1) mrr = (esel == N - 1) ? 1 : esel + 1;
        end
        mlock = (ereq && !egnt) ? esel : -1;
        for (int i = 1; i < N; i++) begin
            if (egnt && esel == i) mstv[i] = 0;
            else if (pr[i])        mstv[i] = (mstv[i] >= LIM) ? LIM : mstv[i] + 1;
            else                   mstv[i] = 0;
        end
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model at the rising edge.
    task automatic applyStimulus();
        packInputs();
        @(negedge clk_i);
        checkOutput();
        @(posedge clk_i);
        modelUpdate();
        #1;
    endtask

    task automatic doReset();
        idle();
        packInputs();
        rst_ni = 1'b0;
        mq.delete();
        for (int i = 0; i < N; i++) mstv[i] = 0;
        mrr = 1; mlock = -1; merr = 1'b0; erv_q = '0; erdata_q = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        bit found;
        int rv1cnt;
        for (int p = 0; p < N; p++) begin
            pr[p] = 1'b0; pw[p] = 1'b0; pbe[p] = '0; pa[p] = '0; pd[p] = '0;
        end
        drdata = '0;

        // Reset state
        doReset();
        applyStimulus();
        compare("reset gnt_o", 64'(s_gnt), 64'(0));
        compare("reset data_req_o", 64'(s_req), 64'(0));
        compare("reset outstanding_o", 64'(s_out), 64'(0));
        compare("reset err_o", 64'(s_err), 64'(0));

        // Single CPU read, response two cycles after the grant
        dgnt = 1'b1;
        setReq(0, 1'b0, 32'h100);
        applyStimulus();
        compare("cpu read gnt", 64'(s_gnt), 64'(3'b001));
        compare("cpu read addr", 64'(s_addr), 64'(32'h100));
        pr[0] = 1'b0;
        applyStimulus();
        drv = 1'b1; drdata = 32'hDEADBEEF; found = 1'b0;
        applyStimulus();
        if (s_rv == 3'b001 && s_rdata == 32'hDEADBEEF) found = 1'b1;
        drv = 1'b0;
        applyStimulus();
        if (s_rv == 3'b001 && s_rdata == 32'hDEADBEEF) found = 1'b1;
        compare("cpu read response", 64'(found), 64'(1));

        // Round-robin between engines
        doReset();
        dgnt = 1'b1;
        setReq(1, 1'b0, 32'h1000);
        setReq(2, 1'b0, 32'h2000);
        for (int i = 0; i < 4; i++) begin
            drv = (mq.size() > 0);
            applyStimulus();
            compare("round robin gnt", 64'(s_gnt), (i % 2 == 0) ? 64'(3'b010) : 64'(3'b100));
        end

        // Starvation override on the 9th waiting cycle
        doReset();
        dgnt = 1'b1;
        setReq(0, 1'b0, 32'h40);
        setReq(1, 1'b0, 32'h1040);
        for (int i = 1; i <= 10; i++) begin
            drv = (mq.size() > 0);
            applyStimulus();
            compare("starve gnt", 64'(s_gnt), (i == 9) ? 64'(3'b010) : 64'(3'b001));
        end

        // Address phase held while downstream stalls
        doReset();
        setReq(1, 1'b0, 32'h200);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) setReq(0, 1'b0, 32'h300);
            applyStimulus();
            compare("lock addr", 64'(s_addr), 64'(32'h200));
            compare("lock gnt", 64'(s_gnt), 64'(0));
        end
        dgnt = 1'b1;
        applyStimulus();
        compare("lock release gnt", 64'(s_gnt), 64'(3'b010));
        pr[1] = 1'b0;
        applyStimulus();
        compare("after lock gnt", 64'(s_gnt), 64'(3'b001));

        // Outstanding limit
        doReset();
        dgnt = 1'b1;
        setReq(0, 1'b0, 32'h500);
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            compare("fill gnt", 64'(s_gnt), 64'(3'b001));
        end
        applyStimulus();
        compare("full data_req_o", 64'(s_req), 64'(0));
        compare("full outstanding_o", 64'(s_out), 64'(4));
        drv = 1'b1;
        applyStimulus();
        compare("full+pop data_req_o", 64'(s_req), 64'(0));
        drv = 1'b0;
        applyStimulus();
        compare("resume gnt", 64'(s_gnt), 64'(3'b001));
        compare("resume outstanding_o", 64'(s_out), 64'(3));

        // Dropped write response and spurious response error
        doReset();
        dgnt = 1'b1;
        setReq(1, 1'b1, 32'h400);
        applyStimulus();
        setReq(1, 1'b0, 32'h404);
        applyStimulus();
        pr[1] = 1'b0;
        rv1cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drv = (mq.size() > 0);
            drdata = $urandom;
            applyStimulus();
            rv1cnt += int'(s_rv[1]);
        end
        compare("drop write rvalid count", 64'(rv1cnt), 64'(1));
        drv = 1'b1;
        applyStimulus();
        drv = 1'b0;
        applyStimulus();
        compare("spurious err_o", 64'(s_err), 64'(1));

        // Randomized OBI traffic
        doReset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int p = 0; p < N; p++)
                if (!pr[p] && $urandom_range(0, (p == 0) ? 1 : 3) == 0)
                    setReq(p, 1'($urandom), $urandom);
            dgnt   = ($urandom_range(0, 9) < 7);
            drv    = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            drdata = $urandom;
            applyStimulus();
            if (egnt) pr[esel] = 1'b0;
        end

        // Reset with transactions in flight; a late response is an error
        idle();
        dgnt = 1'b1;
        setReq(0, 1'b0, 32'h600);
        applyStimulus();
        applyStimulus();
        doReset();
        drv = 1'b1;
        applyStimulus();
        drv = 1'b0;
        applyStimulus();
        compare("late response err_o", 64'(s_err), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
